// File: rtl/phase_acc_pkg.sv
// Shared definitions for the multi-channel phase accumulator: default
// sizing, write-select encodings and an address-width sanity helper.
package phase_acc_pkg;

  localparam int DEFAULT_RESOLUTION = 32;
  localparam int DEFAULT_CHANNELS   = 4;
  localparam int DEFAULT_ADDR_W     = 4;

  // wr_sel encodings: which staging word of the addressed channel is written.
  localparam logic SEL_FREQ = 1'b0;
  localparam logic SEL_OFF  = 1'b1;

  // Smallest address width that can name every channel (at least one bit).
  function automatic int min_addr_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // True when an ADDR_W-bit address can reach all channels.
  function automatic bit addr_w_fits(input int channels, input int addr_w);
    return addr_w >= min_addr_w(channels);
  endfunction

endpackage

// File: rtl/phase_accumulator_mc_if.sv
// Host-side bus of the phase accumulator: staging writes, commit, clear
// mask in; registered phase words and status pulses out.
interface phase_accumulator_mc_if
  import phase_acc_pkg::*;
#(
  parameter int RESOLUTION = DEFAULT_RESOLUTION,
  parameter int CHANNELS   = DEFAULT_CHANNELS,
  parameter int ADDR_W     = DEFAULT_ADDR_W
) ();

  logic                           wr_en;
  logic                           wr_sel;
  logic [ADDR_W-1:0]              wr_addr;
  logic [RESOLUTION-1:0]          wr_data;
  logic                           commit;
  logic [CHANNELS-1:0]            clear;
  logic [CHANNELS*RESOLUTION-1:0] phase_out;
  logic                           commit_done;
  logic                           wr_err;

  // Host / control-register side.
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, commit, clear,
    input  phase_out, commit_done, wr_err
  );

  // Accumulator side.
  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, commit, clear,
    output phase_out, commit_done, wr_err
  );

endinterface

// File: rtl/phase_acc_channel.sv
// One accumulator channel: staging words, active words, the running
// accumulator and the registered, offset-adjusted phase output.
module phase_acc_channel
  import phase_acc_pkg::*;
#(
  parameter int RESOLUTION = DEFAULT_RESOLUTION
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  freq_we,
  input  logic                  off_we,
  input  logic [RESOLUTION-1:0] wr_data,
  input  logic                  commit,
  input  logic                  clear,
  output logic [RESOLUTION-1:0] phase
);

  logic [RESOLUTION-1:0] freq_stage;
  logic [RESOLUTION-1:0] off_stage;
  logic [RESOLUTION-1:0] freq_act;
  logic [RESOLUTION-1:0] off_act;
  logic [RESOLUTION-1:0] acc;

  // Staging registers take host writes and persist across commits.
  // NOTE: every register here is a handful of flops, not a RAM, so each one
  // gets the asynchronous reset; the whole channel restarts from a known zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all state, so every register in
      // this module samples pre-edge values regardless of block order.
      freq_stage <= '0;
      off_stage  <= '0;
    end else begin
      if (freq_we) freq_stage <= wr_data;
      if (off_we)  off_stage  <= wr_data;
    end
  end

  // Commit copies staged words to the active set, forwarding a same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_act <= '0;
      off_act  <= '0;
    end else if (commit) begin
      freq_act <= freq_we ? wr_data : freq_stage;
      off_act  <= off_we  ? wr_data : off_stage;
    end
  end

  // Accumulator: wraps silently; clear overrides the increment for one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else begin
      acc <= acc + freq_act;
    end
  end

  // Output stage: offset is applied after the accumulator, so retuning the
  // offset shifts phase without touching the running frequency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else begin
      phase <= acc + off_act;
    end
  end

endmodule

// File: rtl/phase_accumulator_mc.sv
// Multi-channel NCO phase accumulator. Decodes host writes into per-channel
// staging enables, fans commit/clear out to the channels, and generates the
// commit_done and wr_err status pulses.
module phase_accumulator_mc
  import phase_acc_pkg::*;
#(
  parameter int RESOLUTION = DEFAULT_RESOLUTION,
  parameter int CHANNELS   = DEFAULT_CHANNELS,
  parameter int ADDR_W     = DEFAULT_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  phase_accumulator_mc_if.slave  bus
);

  if (!addr_w_fits(CHANNELS, ADDR_W)) begin : g_bad_addr_w
    $error("phase_accumulator_mc: ADDR_W too narrow for CHANNELS");
  end

  logic                                 addr_ok;
  logic [CHANNELS-1:0]                  freq_we;
  logic [CHANNELS-1:0]                  off_we;
  logic [CHANNELS-1:0][RESOLUTION-1:0]  phase_arr;

  assign addr_ok = int'(bus.wr_addr) < CHANNELS;

  // Address decode: one staging write enable per channel and word type.
  always_comb begin
    // NOTE: defaults first so every path assigns both vectors and no latch
    // is inferred for channels that are not addressed.
    freq_we = '0;
    off_we  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.wr_en && (bus.wr_addr == ADDR_W'(c))) begin
        if (bus.wr_sel == SEL_FREQ) freq_we[c] = 1'b1;
        else                        off_we[c]  = 1'b1;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    phase_acc_channel #(
      .RESOLUTION (RESOLUTION)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .freq_we (freq_we[c]),
      .off_we  (off_we[c]),
      .wr_data (bus.wr_data),
      .commit  (bus.commit),
      .clear   (bus.clear[c]),
      .phase   (phase_arr[c])
    );
  end

  assign bus.phase_out = phase_arr;

  // Status pulses: one cycle after a commit or an out-of-range write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.commit_done <= 1'b0;
      bus.wr_err      <= 1'b0;
    end else begin
      bus.commit_done <= bus.commit;
      bus.wr_err      <= bus.wr_en && !addr_ok;
    end
  end

endmodule

// File: tb/tb_phase_accumulator_mc.sv
// Self-checking bench for phase_accumulator_mc (4 channels x 32 bits).
module tb_phase_accumulator_mc;

  localparam int RES = 32;
  localparam int CH  = 4;
  localparam int AW  = 4;

  logic clk;
  logic reset;

  phase_accumulator_mc_if #(.RESOLUTION(RES), .CHANNELS(CH), .ADDR_W(AW)) bus ();

  phase_accumulator_mc #(.RESOLUTION(RES), .CHANNELS(CH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic        sel;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        cm;
    logic [3:0]  clr;
    logic [31:0] p0, p1, p2, p3;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic we, input logic sel, input logic [3:0] addr,
                              input logic [31:0] data, input logic cm, input logic [3:0] clr,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3,
                              input logic done, input logic err);
    vec_t v;
    v.we = we; v.sel = sel; v.addr = addr; v.data = data; v.cm = cm; v.clr = clr;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.done = done; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] ph(input int c);
    return bus.phase_out[c*RES +: RES];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic sel, input logic [3:0] addr,
                       input logic [31:0] data, input logic cm, input logic [3:0] clr);
    bus.wr_en   = we;
    bus.wr_sel  = sel;
    bus.wr_addr = addr;
    bus.wr_data = data;
    bus.commit  = cm;
    bus.clear   = clr;
  endtask

  // Apply inputs for one edge, then sample 1 ns after it.
  task automatic apply(input logic we, input logic sel, input logic [3:0] addr,
                       input logic [31:0] data, input logic cm, input logic [3:0] clr);
    drive(we, sel, addr, data, cm, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'b0000);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'b0000);

    // Stimulus table: one row per clock edge, expected outputs after it.
    //               we    sel   addr  data          cm    clr      p0            p1            p2        p3     done  err
    vecs[0]  = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 4'd0, 32'h01000000, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        32'h0,    32'h0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h01000000, 32'h0,        32'h0,    32'h0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h02000000, 32'h0,        32'h0,    32'h0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 4'd1, 32'h80000000, 1'b0, 4'b0000, 32'h03000000, 32'h0,        32'h0,    32'h0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'b0000, 32'h04000000, 32'h0,        32'h0,    32'h0, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h05000000, 32'h0,        32'h0,    32'h0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h06000000, 32'h80000000, 32'h0,    32'h0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h07000000, 32'h0,        32'h0,    32'h0, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h08000000, 32'h80000000, 32'h0,    32'h0, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 4'd2, 32'h00000010, 1'b1, 4'b0000, 32'h09000000, 32'h0,        32'h0,    32'h0, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h0A000000, 32'h80000000, 32'h0,    32'h0, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h0B000000, 32'h0,        32'h10,   32'h0, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h0C000000, 32'h80000000, 32'h20,   32'h0, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'b0000, 32'h0D000000, 32'h0,        32'h30,   32'h0, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'b0000, 32'h0E000000, 32'h80000000, 32'h40,   32'h0, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h0F000000, 32'h0,        32'h50,   32'h0, 1'b0, 1'b0);
    vecs[19] = mk(1'b1, 1'b0, 4'd5, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h10000000, 32'h80000000, 32'h60,   32'h0, 1'b0, 1'b1);
    vecs[20] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h11000000, 32'h0,        32'h70,   32'h0, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b1, 4'b0000, 32'h12000000, 32'h80000000, 32'h80,   32'h0, 1'b1, 1'b0);
    vecs[22] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h13000000, 32'h0,        32'h90,   32'h0, 1'b0, 1'b0);
    vecs[23] = mk(1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'b0000, 32'h14000000, 32'h80000000, 32'hA0,   32'h0, 1'b0, 1'b0);

    // Reset state, before any clock edge.
    #3;
    check("reset phase0", ph(0), 32'h0);
    check("reset phase3", ph(3), 32'h0);
    check("reset commit_done", 32'(bus.commit_done), 32'h0);
    check("reset wr_err", 32'(bus.wr_err), 32'h0);
    #9 reset = 1'b0;

    // Table run: ch0 ramp, ch1 wrap-around, ch2 forwarded commit,
    // back-to-back commits, out-of-range write leaving stage registers intact.
    for (int i = 0; i < 24; i++) begin
      apply(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].data, vecs[i].cm, vecs[i].clr);
      check($sformatf("row%0d phase0", i), ph(0), vecs[i].p0);
      check($sformatf("row%0d phase1", i), ph(1), vecs[i].p1);
      check($sformatf("row%0d phase2", i), ph(2), vecs[i].p2);
      check($sformatf("row%0d phase3", i), ph(3), vecs[i].p3);
      check($sformatf("row%0d commit_done", i), 32'(bus.commit_done), 32'(vecs[i].done));
      check($sformatf("row%0d wr_err", i), 32'(bus.wr_err), 32'(vecs[i].err));
    end

    // Fresh start for the offset and clear sequences.
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'b0000);
    reset = 1'b1;
    #2 reset = 1'b0;

    // ch0 F=0x100 (write+commit), ch1 F=0x1000.
    apply(1'b1, 1'b0, 4'd0, 32'h100, 1'b1, 4'b0000);          // E1
    check("seq E1 phase0", ph(0), 32'h0);
    check("seq E1 commit_done", 32'(bus.commit_done), 32'h1);
    apply(1'b1, 1'b0, 4'd1, 32'h1000, 1'b0, 4'b0000);         // E2
    check("seq E2 phase0", ph(0), 32'h0);
    apply(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0000);            // E3
    check("seq E3 phase0", ph(0), 32'h100);
    idle();                                                   // E4
    check("seq E4 phase0", ph(0), 32'h200);
    apply(1'b1, 1'b1, 4'd0, 32'h40000000, 1'b0, 4'b0000);     // E5 stage offset
    check("seq E5 phase0", ph(0), 32'h300);
    check("seq E5 phase1", ph(1), 32'h1000);
    apply(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'b0000);            // E6 commit offset
    check("seq E6 phase0", ph(0), 32'h400);
    idle();                                                   // E7 single jump
    check("seq E7 offset jump", ph(0), 32'h40000500);
    idle();                                                   // E8
    check("seq E8 phase0", ph(0), 32'h40000600);
    idle();                                                   // E9
    check("seq E9 phase0", ph(0), 32'h40000700);

    // Clear ch0 together with a forwarded freq=0x200 commit.
    apply(1'b1, 1'b0, 4'd0, 32'h200, 1'b1, 4'b0001);          // E10
    check("seq E10 phase0", ph(0), 32'h40000800);
    check("seq E10 phase1", ph(1), 32'h6000);
    idle();                                                   // E11
    check("seq E11 phase0 off", ph(0), 32'h40000000);
    check("seq E11 phase1", ph(1), 32'h7000);
    idle();                                                   // E12
    check("seq E12 phase0 off+F", ph(0), 32'h40000200);
    check("seq E12 phase1", ph(1), 32'h8000);
    idle();                                                   // E13
    check("seq E13 phase0", ph(0), 32'h40000400);
    check("seq E13 phase1", ph(1), 32'h9000);

    // Address boundary: CHANNELS is out of range, CHANNELS-1 is not.
    apply(1'b1, 1'b0, 4'd4, 32'h0, 1'b0, 4'b0000);            // E14
    check("addr4 wr_err", 32'(bus.wr_err), 32'h1);
    apply(1'b1, 1'b0, 4'd3, 32'h0, 1'b0, 4'b0000);            // E15
    check("addr3 wr_err", 32'(bus.wr_err), 32'h0);

    // Commit plus bad write, then asynchronous reset mid-cycle.
    apply(1'b1, 1'b0, 4'd5, 32'h0, 1'b1, 4'b0000);            // E16
    check("pre-reset commit_done", 32'(bus.commit_done), 32'h1);
    check("pre-reset wr_err", 32'(bus.wr_err), 32'h1);
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'b0000);
    #2 reset = 1'b1;
    #1;
    check("async reset phase0", ph(0), 32'h0);
    check("async reset phase1", ph(1), 32'h0);
    check("async reset commit_done", 32'(bus.commit_done), 32'h0);
    check("async reset wr_err", 32'(bus.wr_err), 32'h0);
    #2 reset = 1'b0;
    idle();
    check("post-reset phase0", ph(0), 32'h0);
    check("post-reset phase1", ph(1), 32'h0);
    idle();
    check("post-reset freq cleared", ph(1), 32'h0);
    check("post-reset off cleared", ph(0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
